// File: rtl/fifo_wr_ctrl_param.sv
// Write-side controller of the async FIFO with a parametrised depth.
// It keeps the write pointers and drives the RAM write port.
// It also produces registered full, almost_full, level and sticky overflow outputs.
module fifo_wr_ctrl_param #(
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  w_inc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    input  logic                  w_clr_ovf,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int PW = ADDR_WIDTH + 1;
    // The write pointer equals the read pointer with its top two Gray bits inverted exactly when the FIFO is full.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_n;
    logic [PW-1:0] wgray_n;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_n;
    logic          full_n;
    logic          afull_n;

    assign wr_en = w_inc & ~full;
    assign waddr = wbin[ADDR_WIDTH-1:0];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        rbin    = '0;
        wbin_n  = wbin + {{(PW-1){1'b0}}, wr_en};
        wgray_n = (wbin_n >> 1) ^ wbin_n;
        // Gray-to-binary: bit i is the XOR of all Gray bits at position i and above.
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
        level_n = wbin_n - rbin;
        full_n  = (wgray_n == (wq2_rptr ^ FULL_MASK));
        afull_n = (level_n >= AFULL_LVL);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin        <= '0;
            wptr        <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
            wbin        <= wbin_n;
            wptr        <= wgray_n;
            full        <= full_n;
            almost_full <= afull_n;
            wr_level    <= level_n;
            // When a set and a clear arrive in the same cycle, the set wins.
            if (w_inc && full) begin
                overflow <= 1'b1;
            end else if (w_clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl_param.sv
// Randomised scoreboard bench for fifo_wr_ctrl_param (depth 8, almost_full at 6).
// The model counts total writes and reads as integers and derives all expectations from them.
module tb_fifo_wr_ctrl_param;

    typedef struct {
        logic       wr_en;
        logic [2:0] waddr_pre;
        logic [3:0] wptr;
        logic [2:0] waddr;
        logic       full;
        logic       afull;
        logic [3:0] level;
        logic       ovf;
    } exp_t;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       w_inc;
    logic [3:0] wq2_rptr;
    logic       w_clr_ovf;
    logic       wr_en;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_level;
    logic       overflow;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    int   wr_total;
    int   rd_total;
    logic m_full;
    logic m_ovf;

    fifo_wr_ctrl_param #(.ADDR_WIDTH(3), .AFULL_THRESH(6)) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .w_inc       (w_inc),
        .wq2_rptr    (wq2_rptr),
        .w_clr_ovf   (w_clr_ovf),
        .wr_en       (wr_en),
        .waddr       (waddr),
        .wptr        (wptr),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
        .overflow    (overflow)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] to_gray(input int n);
        logic [3:0] b;
        b = 4'(n % 16);
        return b ^ (b >> 1);
    endfunction

    // Drive one cycle of stimulus and push the expected response.
    task automatic cycle(input logic w, input logic clr, input int rd_adv);
        exp_t e;
        int   lvl;
        logic acc;
        @(negedge wclk);
        rd_total += rd_adv;
        w_inc     = w;
        w_clr_ovf = clr;
        wq2_rptr  = to_gray(rd_total);
        acc         = w && !m_full;
        e.wr_en     = acc;
        e.waddr_pre = 3'(wr_total % 8);
        if (w && m_full) m_ovf = 1'b1;
        else if (clr)    m_ovf = 1'b0;
        if (acc) wr_total++;
        lvl     = wr_total - rd_total;
        m_full  = (lvl == 8);
        e.wptr  = to_gray(wr_total);
        e.waddr = 3'(wr_total % 8);
        e.full  = m_full;
        e.afull = (lvl >= 6);
        e.level = 4'(lvl);
        e.ovf   = m_ovf;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge wclk);
            n++;
        end
        check("drain_timeout", 32'(sb_q.size()), 0);
        @(posedge wclk);
        #3;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wptr"},  32'(wptr), 0);
        check({tag, "_waddr"}, 32'(waddr), 0);
        check({tag, "_full"},  32'(full), 0);
        check({tag, "_afull"}, 32'(almost_full), 0);
        check({tag, "_level"}, 32'(wr_level), 0);
        check({tag, "_ovf"},   32'(overflow), 0);
    endtask

    // Monitor: wr_en/waddr before the edge, then registered outputs #1 after it.
    initial begin
        exp_t       e;
        logic [3:0] pre_ptr;
        forever begin
            @(negedge wclk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("wr_en", 32'(wr_en), 32'(e.wr_en));
                check("waddr_pre", 32'(waddr), 32'(e.waddr_pre));
                pre_ptr = wptr;
                @(posedge wclk);
                #1;
                check("wptr", 32'(wptr), 32'(e.wptr));
                check("gray_step", 32'($countones(wptr ^ pre_ptr) <= 1), 1);
                check("waddr", 32'(waddr), 32'(e.waddr));
                check("full", 32'(full), 32'(e.full));
                check("almost_full", 32'(almost_full), 32'(e.afull));
                check("wr_level", 32'(wr_level), 32'(e.level));
                check("overflow", 32'(overflow), 32'(e.ovf));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int adv;
        wrst_n = 1'b0; w_inc = 1'b0; w_clr_ovf = 1'b0; wq2_rptr = 4'd0;
        wr_total = 0; rd_total = 0; m_full = 1'b0; m_ovf = 1'b0;
        #12;
        check_zero("reset");
        check("reset_wr_en", 32'(wr_en), 0);
        @(negedge wclk);
        wrst_n = 1'b1;

        // Fill from empty, then push against full, then clear overflow.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 0);
        // Two reads then one more.
        cycle(1'b0, 1'b0, 2);
        cycle(1'b0, 1'b0, 1);
        // Streaming with the read pointer two behind, across several wraps.
        for (int i = 0; i < 40; i++) begin
            adv = (wr_total - 2 > rd_total) ? (wr_total - 2 - rd_total) : 0;
            cycle(1'b1, 1'b0, adv);
        end
        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            adv = int'($urandom_range(0, 2));
            if (rd_total + adv > wr_total) adv = wr_total - rd_total;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, adv);
        end
        // Fill to full, keep writing, then reset mid-burst.
        n = 0;
        while (!m_full && n < 20) begin
            cycle(1'b1, 1'b0, 0);
            n++;
        end
        check("fill_reached_full", 32'(m_full), 1);
        cycle(1'b1, 1'b0, 0);
        drain();
        check("pre_reset_full", 32'(full), 1);
        wrst_n = 1'b0;
        w_inc = 1'b0; w_clr_ovf = 1'b0; wq2_rptr = 4'd0;
        #1;
        check_zero("async_reset");
        wr_total = 0; rd_total = 0; m_full = 1'b0; m_ovf = 1'b0;
        @(negedge wclk);
        wrst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
